// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
package pipe_pkg;

  // Stage fill state: nothing held, main slot held, main and skid slots held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } pipeStateT;

  // Widest control payload supported; CTRL_NOP is sliced down to CTRL_W.
  localparam int CTRL_MAX_W = 256;

  // Bubble control word: all-zero so downstream treats it as a NOP.
  localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

  // Occupancy encoding, beats held.
  localparam logic [1:0] OCC_ZERO = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  // Occupancy follows directly from the fill state.
  function automatic logic [1:0] stateToOcc(input pipeStateT s);
    case (s)
      MAIN:    return OCC_ONE;
      FULL:    return OCC_TWO;
      default: return OCC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid flag plus datapath and control payloads.
// Clear invalidates the slot and zeroes control; data is left as-is.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic [CTRL_W-1:0] loadCtrl,
  output logic              slotValid,
  output logic [DATA_W-1:0] slotData,
  output logic [CTRL_W-1:0] slotCtrl
);

  // Slot register; clear has priority so flush always wins over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotValid <= 1'b0;
      slotData  <= '0;
      slotCtrl  <= CTRL_NOP[CTRL_W-1:0];
    end else if (clear) begin
      slotValid <= 1'b0;
      slotCtrl  <= CTRL_NOP[CTRL_W-1:0];
    end else if (load) begin
      slotValid <= loadValid;
      slotData  <= loadData;
      slotCtrl  <= loadCtrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, stall,
// flush (bubble insertion) and an optional skid slot that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 10,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipeStateT stateReg;
  pipeStateT stateNext;

  logic inAccept;
  logic outAccept;

  logic mainLoad;
  logic mainClear;
  logic mainFromSkid;
  logic skidLoad;
  logic skidClear;

  logic              mainValid;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic              mainLoadValid;
  logic [DATA_W-1:0] mainLoadData;
  logic [CTRL_W-1:0] mainLoadCtrl;

  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;

  logic [CNT_W-1:0] flushCntReg;

  // Ready path: registered from state with a skid slot, combinational without.
  generate
    if (SKID != 0) begin : gReadySkid
      assign in_ready = (stateReg != FULL);
    end else begin : gReadyComb
      assign in_ready = !mainValid || out_ready;
    end
  endgenerate

  assign inAccept  = in_valid && in_ready;
  assign outAccept = mainValid && out_ready;

  // The main slot refills from the skid slot when draining FULL, else from upstream.
  assign mainLoadValid = mainFromSkid ? skidValid : 1'b1;
  assign mainLoadData  = mainFromSkid ? skidData  : in_data;
  assign mainLoadCtrl  = mainFromSkid ? skidCtrl  : in_ctrl;

  pipe_slot #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) uMain (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mainLoad),
    .clear     (mainClear),
    .loadValid (mainLoadValid),
    .loadData  (mainLoadData),
    .loadCtrl  (mainLoadCtrl),
    .slotValid (mainValid),
    .slotData  (mainData),
    .slotCtrl  (mainCtrl)
  );

  generate
    if (SKID != 0) begin : gSkid
      pipe_slot #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
      ) uSkid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skidLoad),
        .clear     (skidClear),
        .loadValid (1'b1),
        .loadData  (in_data),
        .loadCtrl  (in_ctrl),
        .slotValid (skidValid),
        .slotData  (skidData),
        .slotCtrl  (skidCtrl)
      );
    end else begin : gNoSkid
      assign skidValid = 1'b0;
      assign skidData  = '0;
      assign skidCtrl  = '0;
    end
  endgenerate

  // Fill-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= EMPTY;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state and slot controls; flush drops every held and incoming beat.
  always_comb begin
    stateNext    = stateReg;
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (stateReg)
        EMPTY: begin
          if (inAccept) begin
            stateNext = MAIN;
            mainLoad  = 1'b1;
          end
        end
        MAIN: begin
          if (inAccept && outAccept) begin
            mainLoad = 1'b1;
          end else if (inAccept && (SKID != 0)) begin
            stateNext = FULL;
            skidLoad  = 1'b1;
          end else if (outAccept) begin
            stateNext = EMPTY;
            mainClear = 1'b1;
          end
        end
        FULL: begin
          if (outAccept) begin
            stateNext    = MAIN;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
          end
        end
        default: begin
          stateNext = EMPTY;
          mainClear = 1'b1;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of flush cycles for hazard-unit debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushCntReg <= '0;
    end else if (flush && (flushCntReg != '1)) begin
      flushCntReg <= flushCntReg + CNT_W'(1);
    end
  end

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainValid ? mainCtrl : CTRL_NOP[CTRL_W-1:0];
  assign occupancy = stateToOcc(stateReg);
  assign flush_cnt = flushCntReg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: skid build, SKID=0 build and a
// narrow-counter build. Expected beats are queued on input handshakes and
// popped on output handshakes.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  // Shared stimulus for the skid build and the narrow-counter build.
  logic        flush;
  logic        inValid;
  logic [9:0]  inCtrl;
  logic [63:0] inData;
  logic        outReady;

  logic        inReady;
  logic        outValid;
  logic [63:0] outData;
  logic [9:0]  outCtrl;
  logic [1:0]  occ;
  logic [7:0]  flushCnt;

  logic        sInReady;
  logic        sOutValid;
  logic [63:0] sOutData;
  logic [9:0]  sOutCtrl;
  logic [1:0]  sOcc;
  logic [1:0]  sFlushCnt;

  // SKID=0 build.
  logic        zFlush;
  logic        zInValid;
  logic [9:0]  zInCtrl;
  logic [63:0] zInData;
  logic        zOutReady;
  logic        zInReady;
  logic        zOutValid;
  logic [63:0] zOutData;
  logic [9:0]  zOutCtrl;
  logic [1:0]  zOcc;
  logic [7:0]  zFlushCnt;

  int checks = 0;
  int errors = 0;
  int flushModel = 0;
  logic [9:0] expQ[$];

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(10), .SKID(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_ctrl(outCtrl),
    .occupancy(occ), .flush_cnt(flushCnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(10), .SKID(1), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(sInReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(sOutValid), .out_ready(outReady), .out_data(sOutData), .out_ctrl(sOutCtrl),
    .occupancy(sOcc), .flush_cnt(sFlushCnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(10), .SKID(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(zFlush),
    .in_valid(zInValid), .in_ready(zInReady), .in_data(zInData), .in_ctrl(zInCtrl),
    .out_valid(zOutValid), .out_ready(zOutReady), .out_data(zOutData), .out_ctrl(zOutCtrl),
    .occupancy(zOcc), .flush_cnt(zFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dataOf(input logic [9:0] c);
    return {32'hCAFE_0000 | {22'd0, c}, 32'h1234_5678 ^ {22'd0, c}};
  endfunction

  function automatic int satModel(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic drive(input logic v, input logic [9:0] c, input logic ordy, input logic fl);
    inValid  = v;
    inCtrl   = c;
    inData   = dataOf(c);
    outReady = ordy;
    flush    = fl;
  endtask

  // One clock: sample just after the negedge, update the scoreboard, step to the next negedge.
  task automatic advance(output bit oFired, output logic [9:0] gCtrl, output logic [63:0] gData,
                         output logic [9:0] eCtrl, output bit under, output bit iFired,
                         output logic [1:0] occS, output logic rdyS);
    #1;
    oFired = outValid && outReady;
    iFired = inValid && inReady;
    gCtrl  = outCtrl;
    gData  = outData;
    occS   = occ;
    rdyS   = inReady;
    under  = 1'b0;
    eCtrl  = 'x;
    if (oFired) begin
      if (expQ.size() > 0) eCtrl = expQ.pop_front();
      else under = 1'b1;
    end
    if (flush) begin
      expQ.delete();
      flushModel++;
    end else if (iFired) begin
      expQ.push_back(inCtrl);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit oF, un, iF;
    logic [9:0] gC, eC;
    logic [63:0] gD;
    logic [1:0] oc;
    logic rd;
    drive(1'b1, 10'h0C1, 1'b0, 1'b0);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b1, 10'h0C2, 1'b0, 1'b0);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b0, 10'h000, 1'b0, 1'b0);
    checks++;
    if (occ !== 2'd2) begin errors++; $display("FAIL reset_prefill occupancy: got %0d expected 2", occ); end
    else $display("reset_prefill: occupancy=2 (FULL)");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || outCtrl !== 10'h000 || occ !== 2'd0 || inReady !== 1'b1 || flushCnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b ctrl=%h occ=%0d ready=%b fcnt=%0d expected 0 000 0 1 0",
               outValid, outCtrl, occ, inReady, flushCnt);
    end else $display("reset_async: outputs cleared before clock edge");
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    flushModel = 0;
  endtask

  task automatic test_streaming();
    bit oF, un, iF;
    logic [9:0] gC, eC;
    logic [63:0] gD;
    logic [1:0] oc;
    logic rd;
    int beats = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) drive(1'b1, 10'(i), 1'b1, 1'b0);
      else drive(1'b0, 10'h000, 1'b1, 1'b0);
      advance(oF, gC, gD, eC, un, iF, oc, rd);
      if (i >= 2 && i <= 8) begin
        checks++;
        if (oc !== 2'd1) begin errors++; $display("FAIL stream_occ: got %0d expected 1 at beat %0d", oc, i); end
      end
      if (oF) begin
        beats++;
        checks++;
        if (un || gC !== eC || gD !== dataOf(eC)) begin
          errors++;
          $display("FAIL stream_beat: got ctrl=%h data=%h expected ctrl=%h data=%h", gC, gD, eC, dataOf(eC));
        end else $display("stream_beat: ctrl=%h data=%h", gC, gD);
      end
    end
    checks++;
    if (beats != 8) begin errors++; $display("FAIL stream_count: got %0d beats expected 8", beats); end
  endtask

  task automatic test_stall();
    bit oF, un, iF;
    logic [9:0] gC, eC;
    logic [63:0] gD;
    logic [1:0] oc;
    logic rd;
    int cyc = 0;
    int beats = 0;
    int tries;
    for (int i = 0; i < 3; i++) begin
      iF = 1'b0;
      tries = 0;
      while (!iF && tries < 8) begin
        drive(1'b1, 10'(17 + i), (cyc >= 3), 1'b0);
        advance(oF, gC, gD, eC, un, iF, oc, rd);
        if (cyc == 2) begin
          checks++;
          if (rd !== 1'b0 || oc !== 2'd2) begin
            errors++;
            $display("FAIL stall_full: got ready=%b occ=%0d expected ready=0 occ=2", rd, oc);
          end else $display("stall_full: in_ready=0 occupancy=2, 0x013 held upstream");
        end
        if (oF) begin
          beats++;
          checks++;
          if (un || gC !== eC || gD !== dataOf(eC)) begin
            errors++;
            $display("FAIL stall_beat: got ctrl=%h expected ctrl=%h", gC, eC);
          end else $display("stall_beat: ctrl=%h", gC);
        end
        cyc++;
        tries++;
      end
      checks++;
      if (!iF) begin errors++; $display("FAIL stall_accept: beat %0d not accepted within bound", i); end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 10'h000, 1'b1, 1'b0);
      advance(oF, gC, gD, eC, un, iF, oc, rd);
      if (oF) begin
        beats++;
        checks++;
        if (un || gC !== eC || gD !== dataOf(eC)) begin
          errors++;
          $display("FAIL stall_beat: got ctrl=%h expected ctrl=%h", gC, eC);
        end else $display("stall_beat: ctrl=%h", gC);
      end
    end
    checks++;
    if (beats != 3 || expQ.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, %0d pending, expected 3 beats 0 pending", beats, expQ.size());
    end
  endtask

  task automatic test_flush();
    bit oF, un, iF;
    logic [9:0] gC, eC;
    logic [63:0] gD;
    logic [1:0] oc;
    logic rd;
    drive(1'b1, 10'h0A1, 1'b0, 1'b0);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b1, 10'h0A2, 1'b0, 1'b0);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b1, 10'h3FF, 1'b0, 1'b1);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b0, 10'h000, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b0 || outCtrl !== 10'h000 || occ !== 2'd0 || inReady !== 1'b1 || flushCnt !== 8'(flushModel)) begin
      errors++;
      $display("FAIL flush_full: got valid=%b ctrl=%h occ=%0d ready=%b fcnt=%0d expected 0 000 0 1 %0d",
               outValid, outCtrl, occ, inReady, flushCnt, flushModel);
    end else $display("flush_full: stage emptied, flush_cnt=%0d", flushCnt);
    for (int k = 0; k < 3; k++) begin
      advance(oF, gC, gD, eC, un, iF, oc, rd);
      checks++;
      if (oF) begin errors++; $display("FAIL flush_leak: got ctrl=%h expected no beat", gC); end
    end
    // Flush while a beat is leaving: that transfer still completes.
    drive(1'b1, 10'h0B1, 1'b1, 1'b0);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    drive(1'b1, 10'h0B2, 1'b1, 1'b1);
    advance(oF, gC, gD, eC, un, iF, oc, rd);
    checks++;
    if (!oF || un || gC !== eC || gC !== 10'h0B1) begin
      errors++;
      $display("FAIL flush_outgoing: got fired=%b ctrl=%h expected fired=1 ctrl=0b1", oF, gC);
    end else $display("flush_outgoing: ctrl=%h delivered on flush edge", gC);
    drive(1'b0, 10'h000, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b0 || outCtrl !== 10'h000) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b ctrl=%h expected 0 000", outValid, outCtrl);
    end else $display("flush_drop: 0x0b2 discarded");
  endtask

  task automatic test_saturation();
    bit oF, un, iF;
    logic [9:0] gC, eC;
    logic [63:0] gD;
    logic [1:0] oc;
    logic rd;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 10'h000, 1'b1, 1'b1);
      advance(oF, gC, gD, eC, un, iF, oc, rd);
      checks++;
      if (flushCnt !== 8'(satModel(flushModel, 255)) || sFlushCnt !== 2'(satModel(flushModel, 3))) begin
        errors++;
        $display("FAIL sat_count: got fcnt=%0d narrow=%0d expected %0d and %0d",
                 flushCnt, sFlushCnt, satModel(flushModel, 255), satModel(flushModel, 3));
      end else $display("sat_count: fcnt=%0d narrow=%0d", flushCnt, sFlushCnt);
    end
    drive(1'b0, 10'h000, 1'b1, 1'b0);
    checks++;
    if (sFlushCnt !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d expected 3", sFlushCnt); end
  endtask

  task automatic test_skid0();
    zInValid  = 1'b1;
    zInCtrl   = 10'h055;
    zInData   = dataOf(10'h055);
    zOutReady = 1'b0;
    #1;
    checks++;
    if (zInReady !== 1'b1) begin errors++; $display("FAIL skid0_empty_ready: got %b expected 1", zInReady); end
    else $display("skid0_load: ctrl=055 accepted");
    @(posedge clk);
    @(negedge clk);
    zInCtrl = 10'h066;
    zInData = dataOf(10'h066);
    #1;
    checks++;
    if (zOutValid !== 1'b1 || zOutCtrl !== 10'h055 || zInReady !== 1'b0) begin
      errors++;
      $display("FAIL skid0_stall: got valid=%b ctrl=%h ready=%b expected 1 055 0", zOutValid, zOutCtrl, zInReady);
    end else $display("skid0_stall: in_ready=0 while held and stalled");
    #1;
    zOutReady = 1'b1;
    #1;
    checks++;
    if (zInReady !== 1'b1) begin errors++; $display("FAIL skid0_release: got ready=%b expected 1", zInReady); end
    else $display("skid0_release: in_ready=1 in same cycle");
    @(posedge clk);
    @(negedge clk);
    zInValid = 1'b0;
    #1;
    checks++;
    if (zOutCtrl !== 10'h066 || zOutData !== dataOf(10'h066) || zOcc !== 2'd1) begin
      errors++;
      $display("FAIL skid0_reload: got ctrl=%h occ=%0d expected 066 1", zOutCtrl, zOcc);
    end else $display("skid0_reload: ctrl=%h", zOutCtrl);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (zOutValid !== 1'b0 || zOutCtrl !== 10'h000 || zOcc !== 2'd0) begin
      errors++;
      $display("FAIL skid0_drain: got valid=%b ctrl=%h occ=%0d expected 0 000 0", zOutValid, zOutCtrl, zOcc);
    end else $display("skid0_drain: bubble with ctrl=000");
  endtask

  initial begin
    rst_n     = 1'b0;
    zFlush    = 1'b0;
    zInValid  = 1'b0;
    zInCtrl   = '0;
    zInData   = '0;
    zOutReady = 1'b1;
    drive(1'b0, 10'h000, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_saturation();
    test_skid0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
